// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   NUM_REQ                 : number of requesters served
//   state_e                 : arbiter FSM state encoding
package regfile_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   valid : request vector, bit N = requester N
//   last  : index of the requester granted most recently
//   grant : one-hot winner (all zero when nothing is valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // tie: whoever was not served last goes next
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single register-file port.
// One access takes three cycles: IDLE (grant + latch), ACCESS (drive the
// register file), RESP (return registered read data to the winner).
//   clk, rst_n                    : clock, async active-low reset
//   reqN_valid/ready/we/addr_a/addr_b/wdata : requester N access
//   rspN_valid, rsp_data_a/b      : response pulse and shared data
//   rf_address_a/b, rf_write_enable, rf_write_data : register-file drive
//   rf_data_a/b                   : registered read data from the file
//   busy                          : FSM not in IDLE
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr_a,
  input  logic [ADDR_W-1:0] req0_addr_b,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr_a,
  input  logic [ADDR_W-1:0] req1_addr_b,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0] rf_address_a,
  output logic [ADDR_W-1:0] rf_address_b,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              busy
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0] valid, grant, ready, rsp_vld;

  state_e state_q, state_d;
  req_t   req_q,   req_d;
  logic   win_q,   win_d;
  logic   last_q,  last_d;

  assign req_in[0] = '{we: req0_we, addr_a: req0_addr_a, addr_b: req0_addr_b, wdata: req0_wdata};
  assign req_in[1] = '{we: req1_we, addr_a: req1_addr_a, addr_b: req1_addr_b, wdata: req1_wdata};
  assign valid     = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .valid (valid),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;  // req0 takes the first tie
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    win_d           = win_q;
    last_d          = last_q;
    ready           = '0;
    rsp_vld         = '0;
    rsp_data_a      = '0;
    rsp_data_b      = '0;
    rf_address_a    = '0;
    rf_address_b    = '0;
    rf_write_enable = 1'b0;
    rf_write_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          ready   = grant;
          req_d   = req_in[grant[1]];
          win_d   = grant[1];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rf_address_a    = req_q.addr_a;
        rf_address_b    = req_q.addr_b;
        rf_write_enable = req_q.we;
        rf_write_data   = req_q.wdata;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        rsp_vld[win_q] = 1'b1;
        rsp_data_a     = rf_data_a;
        rsp_data_b     = rf_data_b;
        // pointer only moves once the access has actually completed
        last_d         = win_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ready is a combinational path from valid; hold it low while in reset
  assign req0_ready = ready[0] & rst_n;
  assign req1_ready = ready[1] & rst_n;
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [2:0]  req0_addr_a, req0_addr_b;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [2:0]  req1_addr_a, req1_addr_b;
  logic [15:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_data_a, rsp_data_b;
  logic [2:0]  rf_address_a, rf_address_b;
  logic        rf_write_enable;
  logic [15:0] rf_write_data;
  logic [15:0] rf_data_a = '0, rf_data_b = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [8] = '{default: 16'h0};
  logic [15:0] rf_mem  [8] = '{default: 16'h0};

  regfile_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr_a(req0_addr_a), .req0_addr_b(req0_addr_b), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr_a(req1_addr_a), .req1_addr_b(req1_addr_b), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
    .rf_write_enable(rf_write_enable), .rf_write_data(rf_write_data),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file: registered read, write-through on the write port
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_address_a] <= rf_write_data;
    rf_data_a <= rf_write_enable ? rf_write_data : rf_mem[rf_address_a];
    rf_data_b <= (rf_write_enable && rf_address_b == rf_address_a) ? rf_write_data
                                                                    : rf_mem[rf_address_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on grant, pop on response
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id",    {30'd0, rsp1_valid, rsp0_valid}, e.id ? 32'd2 : 32'd1);
          chk("rsp_a",     {16'd0, rsp_data_a}, {16'd0, e.a});
          chk("rsp_b",     {16'd0, rsp_data_b}, {16'd0, e.b});
          chk("rsp_cycle", cyc, e.due);
          if (e.we) ref_mem[e.waddr] = e.wdata;
        end
      end
      chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready || req1_ready) begin
        exp_t n;
        n.id    = req1_ready;
        n.we    = req1_ready ? req1_we     : req0_we;
        n.waddr = req1_ready ? req1_addr_a : req0_addr_a;
        n.wdata = req1_ready ? req1_wdata  : req0_wdata;
        n.a     = n.we ? n.wdata : ref_mem[n.waddr];
        n.b     = req1_ready ? ref_mem[req1_addr_b] : ref_mem[req0_addr_b];
        if (n.we && (req1_ready ? req1_addr_b : req0_addr_b) == n.waddr) n.b = n.wdata;
        n.due   = cyc + 2;
        sb.push_back(n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [2:0] a,
                      input logic [2:0] b, input logic [15:0] d);
    req0_valid = v; req0_we = we; req0_addr_a = a; req0_addr_b = b; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [2:0] a,
                      input logic [2:0] b, input logic [15:0] d);
    req1_valid = v; req1_we = we; req1_addr_a = a; req1_addr_b = b; req1_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 3'd0, 3'd0, 16'h0);
    set1(1'b0, 1'b0, 3'd0, 3'd0, 16'h0);
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_rf_we",  {31'd0, rf_write_enable}, 32'd0);
    chk("rst_rsp",    {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rf_a",   {29'd0, rf_address_a}, 32'd0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // tie after reset: req0 writes r3, req1 writes r5
    set0(1'b1, 1'b1, 3'd3, 3'd3, 16'hBEEF);
    set1(1'b1, 1'b1, 3'd5, 3'd5, 16'h1234);
    @(negedge clk);
    chk("tie0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("tie0_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("acc_we",    {31'd0, rf_write_enable}, 32'd1);
    chk("acc_addr",  {29'd0, rf_address_a}, 32'd3);
    chk("acc_wdata", {16'd0, rf_write_data}, 32'hBEEF);
    chk("acc_busy",  {31'd0, busy}, 32'd1);
    chk("acc_rdy1",  {31'd0, req1_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("resp_v0",   {31'd0, rsp0_valid}, 32'd1);
    chk("resp_a",    {16'd0, rsp_data_a}, 32'hBEEF);
    chk("resp_we0",  {31'd0, rf_write_enable}, 32'd0);
    chk("resp_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("tie0_next1", {31'd0, req1_ready}, 32'd1);
    chk("idle_rsp",   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    tick(); req1_valid = 1'b0;
    repeat (2) tick();

    // alternation with reads; req0 payload changes after its ready
    set0(1'b1, 1'b0, 3'd3, 3'd5, 16'h0);
    set1(1'b1, 1'b0, 3'd5, 3'd3, 16'h0);
    @(negedge clk);
    chk("alt_ready0", {31'd0, req0_ready}, 32'd1);
    chk("alt_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); set0(1'b0, 1'b1, 3'd6, 3'd6, 16'hFFFF);
    @(negedge clk);
    chk("hold_addr_a", {29'd0, rf_address_a}, 32'd3);
    chk("hold_addr_b", {29'd0, rf_address_b}, 32'd5);
    chk("hold_we",     {31'd0, rf_write_enable}, 32'd0);
    tick();
    @(negedge clk);
    chk("rd_a", {16'd0, rsp_data_a}, 32'hBEEF);
    chk("rd_b", {16'd0, rsp_data_b}, 32'h1234);
    tick();
    @(negedge clk);
    chk("alt_next1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    repeat (2) tick();

    // req1 arrives while busy; req0 writes r6 with addr_b == addr_a
    set0(1'b1, 1'b1, 3'd6, 3'd6, 16'h5A5A);
    @(negedge clk);
    chk("busy_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0; set1(1'b1, 1'b0, 3'd5, 3'd6, 16'h0);
    @(negedge clk);
    chk("wait_acc", {31'd0, req1_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("wait_resp", {31'd0, req1_ready}, 32'd0);
    chk("wt_same_b", {16'd0, rsp_data_b}, 32'h5A5A);
    tick();
    @(negedge clk);
    chk("wait_grant", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    repeat (2) tick();

    // req1 raises and drops valid while busy: no access, pointer unchanged
    set0(1'b1, 1'b1, 3'd2, 3'd1, 16'h0F0F);
    @(negedge clk);
    tick(); req0_valid = 1'b0; req1_valid = 1'b1;
    tick(); req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("drop_ready1", {31'd0, req1_ready}, 32'd0);
    chk("drop_busy",   {31'd0, busy}, 32'd0);
    tick();
    set0(1'b1, 1'b0, 3'd2, 3'd2, 16'h0);
    set1(1'b1, 1'b0, 3'd2, 3'd6, 16'h0);
    @(negedge clk);
    chk("drop_tie1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("drop_then0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    repeat (2) tick();

    // reset in the ACCESS cycle of a write
    set0(1'b1, 1'b1, 3'd7, 3'd7, 16'hDEAD);
    @(negedge clk);
    chk("abort_ready", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("abort_we_pre", {31'd0, rf_write_enable}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we",   {31'd0, rf_write_enable}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", {29'd0, rf_address_a}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    tick();
    set0(1'b1, 1'b0, 3'd7, 3'd7, 16'h0);
    set1(1'b1, 1'b0, 3'd7, 3'd3, 16'h0);
    @(negedge clk);
    chk("post_rst_tie0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_tie1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_r7", {16'd0, rsp_data_a}, 32'h0);
    tick();
    @(negedge clk);
    chk("post_rst_next1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    repeat (4) tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
